// File: rtl/sisc_fetch.sv
// ============================================================================
// Module   : sisc_fetch
// Purpose  : Owns PC and IR, fetches instructions over a req/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sisc_fetch #(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_go,
  input  logic          pc_write,
  input  logic          pc_sel,
  input  logic          br_sel,
  input  logic [AW-1:0] br_addr,
  output logic          im_req,
  output logic [AW-1:0] im_addr,
  input  logic          im_ack,
  input  logic [DW-1:0] im_rdata,
  output logic [DW-1:0] ir,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [AW-1:0] pc,
  output logic          ir_valid,
  output logic          busy,
  output logic          fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [AW-1:0] c_one      = AW'(1);
  localparam logic [AW-1:0] c_reset_pc = AW'(RESET_PC);
  localparam logic [7:0]    c_timeout  = 8'(TIMEOUT);

  logic [1:0]    r_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_im_addr;
  logic [DW-1:0] r_ir;
  logic [7:0]    r_cnt;
  logic          r_im_req;
  logic          r_ir_valid;
  logic          r_fault;

  logic [AW-1:0] w_pc_upd;
  logic [7:0]    w_cnt_inc;

  // PC value produced by this edge while IDLE; a fetch in the same cycle uses it.
  always_comb begin
    w_pc_upd = r_pc;
    if (pc_write) begin
      if (!pc_sel)
        w_pc_upd = r_pc + c_one;
      else if (!br_sel)
        w_pc_upd = br_addr;
      else
        w_pc_upd = r_pc + br_addr;
    end
  end

  assign w_cnt_inc = r_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= c_reset_pc;
      r_im_addr  <= '0;
      r_ir       <= '0;
      r_cnt      <= '0;
      r_im_req   <= 1'b0;
      r_ir_valid <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_ir_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pc <= w_pc_upd;
          if (fetch_go) begin
            r_state   <= S_REQ;
            r_im_req  <= 1'b1;
            r_im_addr <= w_pc_upd;
            r_cnt     <= '0;
          end
        end
        S_REQ: begin
          if (im_ack) begin
            r_ir       <= im_rdata;
            r_pc       <= r_pc + c_one;
            r_ir_valid <= 1'b1;
            r_im_req   <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_IDLE;
          end else if (w_cnt_inc == c_timeout) begin
            r_cnt    <= w_cnt_inc;
            r_fault  <= 1'b1;
            r_im_req <= 1'b0;
            r_state  <= S_FAULT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state  <= S_IDLE;
          r_im_req <= 1'b0;
        end
      endcase
    end
  end

  assign im_req   = r_im_req;
  assign im_addr  = r_im_addr;
  assign ir       = r_ir;
  assign opcode   = r_ir[31:28];
  assign mm       = r_ir[27:24];
  assign pc       = r_pc;
  assign ir_valid = r_ir_valid;
  assign busy     = (r_state == S_REQ);
  assign fault    = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_sisc_fetch.sv
// ============================================================================
// Module   : tb_sisc_fetch
// Purpose  : Directed self-checking bench for sisc_fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sisc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_go, pc_write, pc_sel, br_sel;
  logic [15:0] br_addr;
  logic        im_req;
  logic [15:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] ir;
  logic [3:0]  opcode, mm;
  logic [15:0] pc;
  logic        ir_valid, busy, fault;

  int total = 0;
  int bad   = 0;

  sisc_fetch #(.AW(16), .DW(32), .RESET_PC(0), .TIMEOUT(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_go (fetch_go),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .br_sel   (br_sel),
    .br_addr  (br_addr),
    .im_req   (im_req),
    .im_addr  (im_addr),
    .im_ack   (im_ack),
    .im_rdata (im_rdata),
    .ir       (ir),
    .opcode   (opcode),
    .mm       (mm),
    .pc       (pc),
    .ir_valid (ir_valid),
    .busy     (busy),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_go = 0; pc_write = 0; pc_sel = 0; br_sel = 0;
    br_addr = '0; im_ack = 0; im_rdata = '0;
    step(); step();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_im_req", 32'(im_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    rst = 1'b0;
    step();

    // First fetch, ack in the first REQ cycle
    fetch_go = 1; step(); fetch_go = 0;
    check("f1_im_req", 32'(im_req), 32'h1);
    check("f1_im_addr", 32'(im_addr), 32'h0);
    check("f1_busy", 32'(busy), 32'h1);
    im_ack = 1; im_rdata = 32'h8123_0000; step(); im_ack = 0;
    check("f1_ir", ir, 32'h8123_0000);
    check("f1_opcode", 32'(opcode), 32'h8);
    check("f1_mm", 32'(mm), 32'h1);
    check("f1_pc", 32'(pc), 32'h1);
    check("f1_ir_valid", 32'(ir_valid), 32'h1);
    check("f1_im_req_low", 32'(im_req), 32'h0);
    step();
    check("f1_ir_valid_pulse", 32'(ir_valid), 32'h0);

    // Wait states, with fetch_go/pc_write pulsed during REQ
    fetch_go = 1; step(); fetch_go = 0;
    check("ws_im_addr0", 32'(im_addr), 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin fetch_go = 1; pc_write = 1; pc_sel = 1; br_addr = 16'h0777; end
      step();
      fetch_go = 0; pc_write = 0; pc_sel = 0;
      check("ws_im_addr", 32'(im_addr), 32'h1);
      check("ws_busy", 32'(busy), 32'h1);
      check("ws_ir_valid", 32'(ir_valid), 32'h0);
      check("ws_pc", 32'(pc), 32'h1);
    end
    im_ack = 1; im_rdata = 32'h1234_0000; step(); im_ack = 0;
    check("ws_ir_valid_hi", 32'(ir_valid), 32'h1);
    check("ws_pc_after", 32'(pc), 32'h2);
    check("ws_opcode", 32'(opcode), 32'h1);
    check("ws_mm", 32'(mm), 32'h2);
    step();
    check("ws_ir_valid_once", 32'(ir_valid), 32'h0);
    check("ws_idle_busy", 32'(busy), 32'h0);

    // Branches
    pc_write = 1; pc_sel = 1; br_sel = 0; br_addr = 16'h0010; step();
    check("br_abs_10", 32'(pc), 32'h0010);
    br_addr = 16'h0040; step();
    check("br_abs_40", 32'(pc), 32'h0040);
    br_sel = 1; br_addr = 16'hFFF0; step();
    check("br_rel_wrap", 32'(pc), 32'h0030);
    br_sel = 0; br_addr = 16'hFFFF; step();
    check("br_abs_ffff", 32'(pc), 32'hFFFF);
    pc_sel = 0; step(); pc_write = 0;
    check("pc_inc_wrap", 32'(pc), 32'h0000);

    // Simultaneous pc_write and fetch_go
    pc_write = 1; pc_sel = 1; br_sel = 0; br_addr = 16'h0200; fetch_go = 1;
    step();
    pc_write = 0; pc_sel = 0; fetch_go = 0;
    check("sim_im_addr", 32'(im_addr), 32'h0200);
    im_ack = 1; im_rdata = 32'hA500_0000; step(); im_ack = 0;
    check("sim_pc", 32'(pc), 32'h0201);
    check("sim_opcode", 32'(opcode), 32'hA);

    // Timeout
    fetch_go = 1; step(); fetch_go = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      check("to_fault_low", 32'(fault), 32'h0);
      check("to_im_req_hi", 32'(im_req), 32'h1);
    end
    step();
    check("to_fault", 32'(fault), 32'h1);
    check("to_im_req_low", 32'(im_req), 32'h0);
    check("to_busy_low", 32'(busy), 32'h0);
    im_ack = 1; im_rdata = 32'hF000_0000; fetch_go = 1; pc_write = 1; step();
    im_ack = 0; fetch_go = 0; pc_write = 0;
    step();
    check("flt_ir_frozen", ir, 32'hA500_0000);
    check("flt_pc_frozen", 32'(pc), 32'h0201);
    check("flt_sticky", 32'(fault), 32'h1);
    check("flt_im_req", 32'(im_req), 32'h0);
    rst = 1; step(); rst = 0;
    check("flt_rst_fault", 32'(fault), 32'h0);
    check("flt_rst_pc", 32'(pc), 32'h0);
    check("flt_rst_ir", ir, 32'h0);
    step();

    // Reset mid-fetch
    fetch_go = 1; step(); fetch_go = 0;
    check("mf_im_req", 32'(im_req), 32'h1);
    #2 rst = 1;
    #1;
    check("mf_async_im_req", 32'(im_req), 32'h0);
    check("mf_async_busy", 32'(busy), 32'h0);
    step();
    rst = 0;
    im_ack = 1; im_rdata = 32'hF000_0000; step(); im_ack = 0;
    check("mf_late_ir", ir, 32'h0);
    check("mf_late_pc", 32'(pc), 32'h0);
    check("mf_late_ir_valid", 32'(ir_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
